// File: rtl/demlen_4bit_mod10.sv
// demlen_4bit_mod10 -- free-running modulo-MODULUS up counter with
// terminal-count decode. Any out-of-range count returns to zero on the next
// edge. Optional seven-segment decode of the count is enabled by defining
// the macro DEMLEN_SEG7_EN, which adds the SEG output.
module demlen_4bit_mod10 #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic             Clk,
  input  logic             RST,
  output logic [WIDTH-1:0] OUT,
`ifdef DEMLEN_SEG7_EN
  output logic [6:0]       SEG,
`endif
  output logic             TC
);

  // Last legal count; anything at or above it wraps to zero.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_p0;

  // Count register: async clear, otherwise increment below LAST and wrap at
  // or above LAST, which also recovers from illegal states in one edge.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      cnt_p0 <= '0;
    end else if (cnt_p0 < LAST) begin
      cnt_p0 <= cnt_p0 + WIDTH'(1);
    end else begin
      cnt_p0 <= '0;
    end
  end

  assign OUT = cnt_p0;

  // Terminal count decoded from the registered value; illegal states never
  // match LAST, so TC stays low there.
  always_comb begin
    TC = (cnt_p0 == LAST);
  end

`ifdef DEMLEN_SEG7_EN
  // Hex glyph lookup, segments ordered {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  logic [3:0] seg_idx;

  // Segment drive follows the count directly; a cleared count shows "0".
  always_comb begin
    seg_idx = 4'(cnt_p0);
    SEG     = seg7(seg_idx);
  end
`endif

endmodule

// File: tb/tb_demlen_4bit_mod10.sv
// tb_demlen_4bit_mod10 -- self-checking bench for demlen_4bit_mod10.
// Expected count is derived as (edges since last clear) mod MODULUS.
module tb_demlen_4bit_mod10;
  localparam int MOD = 10;
  localparam int W   = 4;

  logic         Clk = 1'b0;
  logic         RST;
  logic [W-1:0] OUT;
  logic         TC;
`ifdef DEMLEN_SEG7_EN
  logic [6:0]   SEG;
`endif

  demlen_4bit_mod10 #(.MODULUS(MOD), .WIDTH(W)) dut (
    .Clk (Clk),
    .RST (RST),
    .OUT (OUT),
`ifdef DEMLEN_SEG7_EN
    .SEG (SEG),
`endif
    .TC  (TC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit rst;
    int n;
    int exp_out;
    int exp_tcs;
  } vec_t;

  vec_t       tbl [8];
  logic [6:0] segtab [16];
  int errors = 0;
  int checks = 0;
  int k = 0;   // edges since the counter was last known to be zero

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_seg(input int v);
`ifdef DEMLEN_SEG7_EN
    chk("seg", 32'(SEG), 32'(segtab[v]));
`endif
  endtask

  // Advance one rising edge, update the reference, sample 1 ns later.
  task automatic edge_check();
    @(posedge Clk);
    if (RST) k++;
    else     k = 0;
    #1;
    chk("out", 32'(OUT), 32'(k % MOD));
    chk("tc", 32'(TC), 32'((k % MOD) == MOD - 1));
    chk_seg(k % MOD);
  endtask

  // 3 ns reset pulse between edges; count must clear at once and restart at 1.
  task automatic pulse_reset();
    #1 RST = 1'b0;
    k = 0;
    #1;
    chk("pulse_out", 32'(OUT), 32'd0);
    chk("pulse_tc", 32'(TC), 32'd0);
    #2 RST = 1'b1;
    edge_check();
  endtask

  initial begin
    int tcs;
    int r;
    segtab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    tbl[0] = '{rst: 1'b0, n: 38, exp_out: 0, exp_tcs: 0};
    tbl[1] = '{rst: 1'b1, n: 38, exp_out: 8, exp_tcs: 3};
    tbl[2] = '{rst: 1'b1, n: 1,  exp_out: 9, exp_tcs: 1};
    tbl[3] = '{rst: 1'b1, n: 1,  exp_out: 0, exp_tcs: 0};
    tbl[4] = '{rst: 1'b1, n: 5,  exp_out: 5, exp_tcs: 0};
    tbl[5] = '{rst: 1'b0, n: 3,  exp_out: 0, exp_tcs: 0};
    tbl[6] = '{rst: 1'b1, n: 10, exp_out: 0, exp_tcs: 1};
    tbl[7] = '{rst: 1'b1, n: 9,  exp_out: 9, exp_tcs: 1};

    // Reset asserted before any clock edge: outputs must be clean zeros.
    RST = 1'b0;
    #1;
    chk("reset_out", 32'(OUT), 32'd0);
    chk("reset_tc", 32'(TC), 32'd0);
    chk_seg(0);

    // Table-driven phases: hold or run for n edges, check final value and TC count.
    foreach (tbl[i]) begin
      if (!tbl[i].rst && RST) begin
        RST = 1'b0;
        k = 0;
        #1;
        chk("async_clear", 32'(OUT), 32'd0);
      end else begin
        RST = tbl[i].rst;
      end
      tcs = 0;
      for (int c = 0; c < tbl[i].n; c++) begin
        edge_check();
        tcs += int'(TC);
      end
      chk($sformatf("vec%0d_out", i), 32'(OUT), 32'(tbl[i].exp_out));
      chk($sformatf("vec%0d_tcs", i), 32'(tcs), 32'(tbl[i].exp_tcs));
    end

    // From 9 advance to 5, then pulse reset mid-count.
    repeat (6) edge_check();
    chk("pre_pulse", 32'(OUT), 32'd5);
    pulse_reset();
    chk("post_pulse", 32'(OUT), 32'd1);

    // Illegal states 10..15 must decode TC low and return to 0 in one edge.
    for (int v = MOD; v < (1 << W); v++) begin
      force dut.cnt_p0 = W'(v);
      #1;
      chk("illegal_out", 32'(OUT), 32'(v));
      chk("illegal_tc", 32'(TC), 32'd0);
      chk_seg(v);
      release dut.cnt_p0;
      @(posedge Clk);
      #1;
      k = 0;
      chk("illegal_next", 32'(OUT), 32'd0);
      chk("illegal_next_tc", 32'(TC), 32'd0);
    end

    // Random mix of run edges, async reset pulses and held reset.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        pulse_reset();
      end else if (r == 1) begin
        RST = 1'b0;
        k = 0;
        repeat ($urandom_range(1, 3)) edge_check();
        RST = 1'b1;
      end else begin
        edge_check();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
